// File: rtl/play_credit_arbiter_pkg.sv
// Shared types and default constants for the play-credit arbiter.
package play_credit_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_REFUND = 2'd2
  } state_e;

  localparam int unsigned DEF_COINS_PER_CREDIT = 2;
  localparam int unsigned DEF_MAX_CREDITS      = 9;
  localparam int unsigned DEF_TIMEOUT_CYCLES   = 16;

  function automatic logic [1:0] player_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/play_credit_arbiter_if.sv
// Coin/start/grant signal bundle between the cabinet logic and the arbiter.
interface play_credit_arbiter_if;

  logic       coin_accepted;
  logic [1:0] start_req;
  logic [1:0] game_busy;
  logic       refund_req;
  logic [1:0] start_grant;
  logic [3:0] credits;
  logic [2:0] partial_coins;
  logic       coin_block;
  logic       spit_pulse;
  logic       refund_busy;

  modport master (
    output coin_accepted, start_req, game_busy, refund_req,
    input  start_grant, credits, partial_coins, coin_block, spit_pulse, refund_busy
  );

  modport slave (
    input  coin_accepted, start_req, game_busy, refund_req,
    output start_grant, credits, partial_coins, coin_block, spit_pulse, refund_busy
  );

endinterface

// File: rtl/play_credit_arbiter_idle_timer.sv
// Inactivity counter: saturates at TIMEOUT_CYCLES-1 and flags done there.
module idle_timer
  import play_credit_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic done
);

  localparam int unsigned    W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0]   LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign done = (cnt_q == LAST);

endmodule

// File: rtl/play_credit_arbiter.sv
// Two-player coin-op credit arbiter: counts coins into credits, grants starts
// round-robin, and refunds partial coins on request or inactivity.
module play_credit_arbiter
  import play_credit_arbiter_pkg::*;
#(
  parameter int unsigned COINS_PER_CREDIT = DEF_COINS_PER_CREDIT,
  parameter int unsigned MAX_CREDITS      = DEF_MAX_CREDITS,
  parameter int unsigned TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
  input logic                 clk,
  input logic                 rst,
  play_credit_arbiter_if.slave bus
);

  localparam logic [2:0] CPC  = 3'(COINS_PER_CREDIT);
  localparam logic [3:0] MAXC = 4'(MAX_CREDITS);

  state_e     state_q, state_d;
  logic [3:0] credits_q, credits_d;
  logic [2:0] partial_q, partial_d;
  logic [2:0] rcnt_q, rcnt_d;
  logic       ptr_q, ptr_d;
  logic       sel_q, sel_d;
  logic       pend_q, pend_d;
  logic [1:0] grant_q, grant_d;
  logic       block_q, block_d;
  logic       spit_q, spit_d;
  logic       busy_q, busy_d;

  logic       accepted, coin_full, grant_dec, timer_clr, timer_done;
  logic [2:0] partial_inc;
  logic [1:0] elig;

  assign accepted    = bus.coin_accepted && !block_q;
  assign partial_inc = partial_q + 3'd1;
  assign coin_full   = accepted && (partial_inc == CPC);
  assign grant_dec   = (state_q == ST_GRANT);
  assign elig        = bus.start_req & ~bus.game_busy;
  assign timer_clr   = accepted || (partial_q == '0) || (state_q == ST_REFUND);

  idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .clr  (timer_clr),
    .done (timer_done)
  );

  always_comb begin
    state_d   = state_q;
    credits_d = credits_q;
    partial_d = partial_q;
    rcnt_d    = rcnt_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    pend_d    = pend_q;
    grant_d   = '0;
    spit_d    = 1'b0;

    if (accepted) begin
      partial_d = coin_full ? '0 : partial_inc;
    end

    // A credit completed in the grant cycle cancels the decrement.
    case ({coin_full, grant_dec})
      2'b10:   credits_d = credits_q + 4'd1;
      2'b01:   credits_d = credits_q - 4'd1;
      default: credits_d = credits_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if ((credits_q != '0) && (elig != '0)) begin
          state_d = ST_GRANT;
          sel_d   = (elig == 2'b11) ? ptr_q : elig[1];
          grant_d = player_onehot(sel_d);
          if (bus.refund_req) pend_d = 1'b1;
        end else if (bus.refund_req || pend_q || timer_done) begin
          pend_d = 1'b0;
          if (partial_d != '0) begin
            state_d = ST_REFUND;
            rcnt_d  = partial_d;
            spit_d  = 1'b1;
          end
        end
      end
      ST_GRANT: begin
        ptr_d   = ~sel_q;
        state_d = ST_IDLE;
        if (bus.refund_req) pend_d = 1'b1;
      end
      ST_REFUND: begin
        if (spit_q) begin
          rcnt_d = rcnt_q - 3'd1;
          if (rcnt_q <= 3'd1) begin
            partial_d = '0;
            state_d   = ST_IDLE;
          end
        end else begin
          spit_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    block_d = (credits_d == MAXC) || (state_d == ST_REFUND);
    busy_d  = (state_d == ST_REFUND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      credits_q <= '0;
      partial_q <= '0;
      rcnt_q    <= '0;
      ptr_q     <= 1'b0;
      sel_q     <= 1'b0;
      pend_q    <= 1'b0;
      grant_q   <= '0;
      block_q   <= 1'b0;
      spit_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
      partial_q <= partial_d;
      rcnt_q    <= rcnt_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      pend_q    <= pend_d;
      grant_q   <= grant_d;
      block_q   <= block_d;
      spit_q    <= spit_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.start_grant   = grant_q;
  assign bus.credits       = credits_q;
  assign bus.partial_coins = partial_q;
  assign bus.coin_block    = block_q;
  assign bus.spit_pulse    = spit_q;
  assign bus.refund_busy   = busy_q;

endmodule
